// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit saturating-counter direction predictor with registered redirect.
// Optional statistics counters are compiled in when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        illegal_branch
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int NUM_ENTRIES = 1 << IDX_BITS;

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                legal;
  logic                actual_taken;
  logic                upd_en;
  logic                mispredict;
  logic [31:0]         next_pc;

  logic [1:0]  cnt_q [NUM_ENTRIES];
  logic [1:0]  cnt_d [NUM_ENTRIES];

  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        illegal_branch_q, illegal_branch_d;

  // Only the index bits of the fetch PC select a counter.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

  assign fetch_idx  = fetch_pc[IDX_BITS+1:2];
  assign ex_idx     = ex_pc[IDX_BITS+1:2];
  assign pred_taken = cnt_q[fetch_idx][1];

  always_comb begin
    legal        = 1'b1;
    actual_taken = 1'b0;
    case (ex_funct3)
      3'b000: actual_taken = br_eq;
      3'b001: actual_taken = !br_eq;
      3'b100: actual_taken = br_lt;
      3'b101: actual_taken = !br_lt;
      3'b110: actual_taken = br_ltu;
      3'b111: actual_taken = !br_ltu;
      3'b010: legal = 1'b0;
      3'b011: legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  assign upd_en     = ex_valid && legal;
  assign mispredict = upd_en && (actual_taken != ex_pred_taken);
  assign next_pc    = actual_taken ? ex_target : (ex_pc + 32'd4);

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic [1:0] entry_d;
      always_comb begin
        entry_d = cnt_q[gi];
        if (upd_en && (ex_idx == IDX_BITS'(gi))) begin
          if (actual_taken) begin
            entry_d = (cnt_q[gi] == 2'b11) ? 2'b11 : cnt_q[gi] + 2'b01;
          end else begin
            entry_d = (cnt_q[gi] == 2'b00) ? 2'b00 : cnt_q[gi] - 2'b01;
          end
        end
      end
      assign cnt_d[gi] = entry_d;
    end
  endgenerate

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? next_pc : redirect_pc_q;
    illegal_branch_d = ex_valid && !legal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      illegal_branch_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_branch_q <= illegal_branch_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal_branch = illegal_branch_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_en && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Consumes the branch comparator flags (`br_eq`, `br_lt`, `br_ltu`) at execute, resolves the actual direction of every conditional branch from `funct3`, and maintains a direct-mapped table of 2-bit saturating counters that fetch queries for a taken/not-taken prediction. On a misprediction it issues a registered one-cycle redirect carrying the correct next PC. It sits between the execute-stage comparator and the fetch-stage PC mux.

## Interface
- `IDX_BITS`, default 4: table index width; the table holds 2^IDX_BITS entries indexed by `pc[IDX_BITS+1:2]`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset. This is the only reset.
- `fetch_pc`  in  32  PC currently in fetch.
- `pred_taken`  out  1  combinational prediction for `fetch_pc`: the MSB of the indexed counter.
- `ex_valid`  in  1  execute-stage instruction is a valid conditional branch.
- `ex_funct3`  in  3  branch `funct3` field.
- `ex_pc`  in  32  PC of the branch being resolved.
- `ex_target`  in  32  computed branch target.
- `ex_pred_taken`  in  1  prediction that fetch made for this branch, carried down the pipeline.
- `br_eq`, `br_lt`, `br_ltu`  in  1 each  comparator flags for `rs1` versus `rs2`.
- `redirect_valid`  out  1  registered; a mispredict was detected on the previous cycle.
- `redirect_pc`  out  32  registered; the correct next PC. Only meaningful while `redirect_valid` is high.
- `illegal_branch`  out  1  registered; the previous cycle's `ex_funct3` was 010 or 011.
- `stat_branches`, `stat_mispredicts`  out  32 each  present only with `BPU_STATS_EN`.

## Operation
- Actual direction by `ex_funct3`:
  - 000 → `br_eq`
  - 001 → `!br_eq`
  - 100 → `br_lt`
  - 101 → `!br_lt`
  - 110 → `br_ltu`
  - 111 → `!br_ltu`
  - 010 and 011 → not taken, and `illegal_branch` is raised. For these encodings the table is not updated and no redirect is issued.
- Mispredict is defined as `ex_valid && legal && (actual != ex_pred_taken)`.
- Correct next PC:
  - taken → `ex_target`
  - not taken → `ex_pc + 4`, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Counter update when `ex_valid` and the encoding is legal, at index `ex_pc[IDX_BITS+1:2]`:
  - taken → increment, saturating at 11
  - not taken → decrement, saturating at 00
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is `counter[1]`.
- `ex_pc[1:0]` and the PC bits above the index are ignored. Aliasing between branches that share an index is permitted.

## Timing
- `pred_taken` has zero latency: a combinational read of the registered table.
- Table update, `redirect_valid`, `redirect_pc` and `illegal_branch` all take effect on the rising edge after the resolving cycle.
- `redirect_valid` is a one-cycle pulse per mispredict. Back-to-back mispredicting branches on consecutive cycles produce consecutive pulses, each carrying its own `redirect_pc`.
- When lookup and update hit the same index in the same cycle, `pred_taken` returns the pre-update value. There is no bypass.
- Two updates to the same index on consecutive cycles both apply in order. For example, 11 followed by two not-taken outcomes gives 01.
- Reset (`rst_n` = 0 at a rising edge):
  - every counter is set to 01
  - `redirect_valid`, `illegal_branch` and `redirect_pc` are set to 0
  - stats counters are set to 0
  - a branch resolving in the same cycle as reset is discarded: no update, no redirect.
- With `ex_valid` = 0, all flag and `funct3` inputs are don't-care and no state changes.

## Configuration
- `BPU_STATS_EN` defined:
  - `stat_branches` increments on each legal resolved branch.
  - `stat_mispredicts` increments on each mispredict.
  - Both saturate at 0xFFFFFFFF and both update on the same edge as the table.
- `BPU_STATS_EN` undefined: both ports and their registers are absent, and all other behaviour is identical.

## Test plan
- After reset, `fetch_pc` = 0x100 → `pred_taken` = 0. Then resolve BEQ at `ex_pc` 0x100 with `br_eq` = 1, `ex_pred_taken` = 0, `ex_target` 0x200 → next cycle `redirect_valid` = 1, `redirect_pc` = 0x200, and `pred_taken` for 0x100 = 1.
- BGEU at `ex_pc` 0x40 with `br_ltu` = 1 and `ex_pred_taken` = 1 → not taken; next cycle `redirect_pc` = 0x44 and the counter moves 01 → 00.
- Resolve the same index taken 4 times, then not taken once → counter 11 then 10, and `pred_taken` stays 1 throughout.
- `ex_funct3` = 010 with `ex_valid` = 1 → `illegal_branch` = 1 for one cycle, `redirect_valid` = 0, and the table is unchanged.
- BNE at `ex_pc` 0xFFFFFFFC, not taken, `ex_pred_taken` = 1 → `redirect_pc` = 0x00000000. Asserting `rst_n` = 0 during a mispredict resolve → no redirect and all counters read back 01.
- With `BPU_STATS_EN`: 3 correct and 2 mispredicted branches → `stat_branches` = 5, `stat_mispredicts` = 2.
